// File: rtl/seg_scan_ctrl.sv
// Wishbone-configured scan controller for an 8-segment x NUM_DIGITS multiplexed
// display: per-digit patterns, programmable dwell, blanking gap, 16-level PWM.
module seg_scan_ctrl #(
   parameter int NUM_DIGITS = 10,
   parameter int DIV_W      = 16,
   parameter int BLANK_CYC  = 4,
   parameter int DIV_RST    = 999
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   input  logic                  wbs_cyc_i,
   input  logic                  wbs_stb_i,
   input  logic                  wbs_we_i,
   input  logic [3:0]            wbs_sel_i,
   input  logic [31:0]           wbs_adr_i,
   input  logic [31:0]           wbs_dat_i,
   output logic [31:0]           wbs_dat_o,
   output logic                  wbs_ack_o,
   output logic [7:0]            segm,
   output logic [NUM_DIGITS-1:0] sel,
   output logic                  frame_o
);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [DIV_W-1:0] BLANK_LAST = DIV_W'(BLANK_CYC - 1);
   localparam logic [4:0]       DIG_END    = 5'(NUM_DIGITS + 2);

   typedef enum logic [1:0] {S_IDLE, S_BLANK, S_ON} state_e;

   // Bus side
   logic                  ack_q;
   logic [31:0]           dat_q;
   logic [31:0]           rdata;
   logic [3:0]            adr;
   logic [3:0]            dig_off;
   logic                  dig_hit;
   logic                  acc;
   logic                  wr;
   logic [31:0]           lane_m;

   // Configuration registers
   logic                  en_q, en_d;
   logic [3:0]            bright_q, bright_d;
   logic [DIV_W-1:0]      div_q, div_d;
   logic [7:0]            digit_q [NUM_DIGITS];
   logic [7:0]            digit_d [NUM_DIGITS];

   // Scan engine
   state_e                state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [DIV_W-1:0]      cnt_q, cnt_d;
   logic [3:0]            pwm_q, pwm_d;
   logic [7:0]            segm_q, segm_d;
   logic [NUM_DIGITS-1:0] sel_q, sel_d;
   logic                  frame_q, frame_d;

   logic                  unused_bits;

   assign adr     = wbs_adr_i[5:2];
   assign dig_off = adr - 4'd2;
   assign dig_hit = (adr >= 4'd2) && ({1'b0, adr} < DIG_END);
   assign acc     = wbs_cyc_i & wbs_stb_i & ~ack_q;
   assign wr      = acc & wbs_we_i;
   assign lane_m  = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                     {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

   // Address and data bits outside the decoded/implemented fields.
   assign unused_bits = ^{wbs_adr_i, wbs_dat_i, dig_off, lane_m};

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;
   assign segm      = segm_q;
   assign sel       = sel_q;
   assign frame_o   = frame_q;

   always_comb begin
      en_d     = en_q;
      bright_d = bright_q;
      div_d    = div_q;
      digit_d  = digit_q;
      if (wr) begin
         if (adr == 4'd0 && wbs_sel_i[0]) begin
            en_d     = wbs_dat_i[0];
            bright_d = wbs_dat_i[7:4];
         end
         if (adr == 4'd1)
            div_d = (div_q & ~lane_m[DIV_W-1:0]) | (wbs_dat_i[DIV_W-1:0] & lane_m[DIV_W-1:0]);
         if (dig_hit && wbs_sel_i[0])
            digit_d[dig_off[IDX_W-1:0]] = wbs_dat_i[7:0];
      end
   end

   always_comb begin
      rdata = '0;
      if (adr == 4'd0)
         rdata[7:0] = {bright_q, 3'd0, en_q};
      else if (adr == 4'd1)
         rdata[DIV_W-1:0] = div_q;
      else if (dig_hit)
         rdata[7:0] = digit_q[dig_off[IDX_W-1:0]];
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ack_q    <= 1'b0;
         dat_q    <= '0;
         en_q     <= 1'b0;
         bright_q <= '0;
         div_q    <= DIV_W'(DIV_RST);
         for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= '0;
      end else begin
         ack_q    <= acc;
         dat_q    <= (acc && !wbs_we_i) ? rdata : '0;
         en_q     <= en_d;
         bright_q <= bright_d;
         div_q    <= div_d;
         digit_q  <= digit_d;
      end
   end

   // Outputs are derived from the next state so they line up with it once registered.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      pwm_d   = pwm_q;
      frame_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            idx_d = '0;
            if (en_q) begin
               state_d = S_BLANK;
               cnt_d   = '0;
               frame_d = 1'b1;
            end
         end
         S_BLANK: begin
            if (!en_q) begin
               state_d = S_IDLE;
            end else if (cnt_q == BLANK_LAST) begin
               state_d = S_ON;
               cnt_d   = '0;
               pwm_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_ON: begin
            if (!en_q) begin
               state_d = S_IDLE;
            end else if (cnt_q >= div_q) begin
               state_d = S_BLANK;
               cnt_d   = '0;
               if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
                  frame_d = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
               pwm_d = pwm_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      sel_d  = '0;
      segm_d = '0;
      if (state_d == S_ON && pwm_d <= bright_q) begin
         sel_d[idx_d] = 1'b1;
         segm_d       = digit_q[idx_d];
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         pwm_q   <= '0;
         segm_q  <= '0;
         sel_q   <= '0;
         frame_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         pwm_q   <= pwm_d;
         segm_q  <= segm_d;
         sel_q   <= sel_d;
         frame_q <= frame_d;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a digit/offset display model and a register
// shadow predict every cycle; a monitor pops and compares against the DUT.
module tb_seg_scan_ctrl;
   localparam int ND   = 10;
   localparam int DW   = 16;
   localparam int BLK  = 4;
   localparam int DRST = 999;

   logic          clk  = 1'b0;
   logic          rst  = 1'b1;
   logic          cyc  = 1'b0;
   logic          stb  = 1'b0;
   logic          we   = 1'b0;
   logic [3:0]    bsel = 4'h0;
   logic [31:0]   adr  = '0;
   logic [31:0]   wdat = '0;
   logic [31:0]   rdat;
   logic          ack;
   logic [7:0]    segm;
   logic [ND-1:0] sel;
   logic          frame;

   seg_scan_ctrl #(.NUM_DIGITS(ND), .DIV_W(DW), .BLANK_CYC(BLK), .DIV_RST(DRST)) dut (
      .wb_clk_i (clk),  .wb_rst_i (rst),  .wbs_cyc_i(cyc),  .wbs_stb_i(stb),
      .wbs_we_i (we),   .wbs_sel_i(bsel), .wbs_adr_i(adr),  .wbs_dat_i(wdat),
      .wbs_dat_o(rdat), .wbs_ack_o(ack),  .segm     (segm), .sel      (sel),
      .frame_o  (frame)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          ack;
      logic          rd;
      logic          frame;
      logic [ND-1:0] sel;
      logic [7:0]    segm;
   } exp_t;

   exp_t        cycq[$];
   logic [31:0] rdq[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   // Register shadow and display position (digit, cycles since that digit's gap began)
   logic          m_en = 1'b0;
   logic [3:0]    m_bright = '0;
   logic [DW-1:0] m_div = '0;
   logic [7:0]    m_dig [ND];
   logic          m_ack = 1'b0;
   logic          m_run = 1'b0;
   int            m_d = 0;
   int            m_off = 0;

   function automatic logic [31:0] model_rd(input int a);
      if (a == 0) return {24'd0, m_bright, 3'd0, m_en};
      if (a == 1) return {16'd0, m_div};
      if (a >= 2 && a < ND + 2) return {24'd0, m_dig[a-2]};
      return 32'd0;
   endfunction

   task automatic model_step();
      exp_t e;
      int   a;
      int   k;
      e = '0;
      if (rst) begin
         m_en = 1'b0; m_bright = '0; m_div = DW'(DRST);
         foreach (m_dig[i]) m_dig[i] = '0;
         m_ack = 1'b0; m_run = 1'b0; m_d = 0; m_off = 0;
      end else begin
         if (!m_en) m_run = 1'b0;
         else if (!m_run) begin m_run = 1'b1; m_d = 0; m_off = 0; end
         else if (m_off >= BLK && (m_off - BLK) >= int'(m_div)) begin
            m_d = (m_d + 1) % ND; m_off = 0;
         end else m_off++;
         if (m_run) begin
            e.frame = (m_off == 0 && m_d == 0);
            k = m_off - BLK;
            if (m_off >= BLK && (k % 16) <= int'(m_bright)) begin
               e.sel  = ND'(1) << m_d;
               e.segm = m_dig[m_d];
            end
         end
         a     = int'(adr[5:2]);
         e.ack = cyc && stb && !m_ack;
         e.rd  = e.ack && !we;
         if (e.ack && we) begin
            if (a == 0 && bsel[0]) begin m_en = wdat[0]; m_bright = wdat[7:4]; end
            if (a == 1) begin
               if (bsel[0]) m_div[7:0]  = wdat[7:0];
               if (bsel[1]) m_div[15:8] = wdat[15:8];
            end
            if (a >= 2 && a < ND + 2 && bsel[0]) m_dig[a-2] = wdat[7:0];
         end
         m_ack = e.ack;
      end
      cycq.push_back(e);
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial begin : monitor
      exp_t        e;
      logic [31:0] want;
      forever begin
         @(posedge clk); #1;
         if (cycq.size() != 0) begin
            e = cycq.pop_front();
            n_cmp++;
            if (ack !== e.ack || frame !== e.frame || sel !== e.sel || segm !== e.segm) begin
               n_bad++;
               $display("FAIL cycle t=%0t: got ack=%b frame=%b sel=%b segm=%h, want ack=%b frame=%b sel=%b segm=%h",
                        $time, ack, frame, sel, segm, e.ack, e.frame, e.sel, e.segm);
            end
            if (ack === 1'b1 && e.rd) begin
               n_cmp++;
               if (rdq.size() == 0) begin
                  n_bad++;
                  $display("FAIL rd_unexpected t=%0t: got read ack data=%h, want no read pending", $time, rdat);
               end else begin
                  want = rdq.pop_front();
                  if (rdat !== want) begin
                     n_bad++;
                     $display("FAIL rdata t=%0t adr=%h: got %h, want %h", $time, adr, rdat, want);
                  end
               end
            end else if (ack !== 1'b1) begin
               n_cmp++;
               if (rdat !== 32'd0) begin
                  n_bad++;
                  $display("FAIL dat_idle t=%0t: got %h, want 0", $time, rdat);
               end
            end
         end
      end
   end

   task automatic bus(input int a, input logic [31:0] d, input logic [3:0] be, input bit w);
      int n;
      @(negedge clk);
      if (!w) rdq.push_back(model_rd(a));
      cyc = 1'b1; stb = 1'b1; we = w; adr = 32'(a) << 2; wdat = d; bsel = be;
      n = 0;
      do begin @(posedge clk); #2; n++; end while (ack !== 1'b1 && n < 8);
      n_cmp++;
      if (ack !== 1'b1) begin
         n_bad++;
         $display("FAIL ack_timeout adr=%0d: got ack=%b, want 1 within 8 cycles", a, ack);
      end
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   // Strobe held high: acks must land on alternate cycles.
   task automatic rd_held(input int a, input int cycles);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'(a) << 2; bsel = 4'hF;
      for (int i = 0; i < cycles; i++) begin
         if (i % 2 == 0) rdq.push_back(model_rd(a));
         @(negedge clk);
      end
      cyc = 1'b0; stb = 1'b0;
   endtask

   task automatic wait_pos(input int d, input int off);
      int n;
      n = 0;
      while (!(m_run && m_d == d && m_off == off) && n < 5000) begin
         @(negedge clk); n++;
      end
      if (!(m_run && m_d == d && m_off == off)) begin
         n_bad++;
         $display("FAIL wait_pos: got digit=%0d off=%0d, want digit=%0d off=%0d", m_d, m_off, d, off);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no end of run, want finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int          a;
      logic [31:0] d;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      // reset readback
      bus(0, 0, 4'hF, 0);
      bus(1, 0, 4'hF, 0);
      bus(15, 0, 4'hF, 0);
      // byte lanes
      bus(1, 32'h0, 4'hF, 1);
      bus(1, 32'h1234, 4'b0001, 1);
      bus(1, 0, 4'hF, 0);
      bus(5, 32'hA5, 4'b0010, 1);
      bus(5, 0, 4'hF, 0);
      // basic scan
      bus(1, 3, 4'hF, 1);
      for (int i = 0; i < ND; i++) bus(2 + i, 32'(i + 1), 4'h1, 1);
      bus(0, 32'hF1, 4'h1, 1);
      repeat (200) @(negedge clk);
      rd_held(0, 4);
      // brightness
      bus(1, 31, 4'hF, 1);
      bus(0, 32'h31, 4'h1, 1);
      repeat (300) @(negedge clk);
      bus(0, 32'h01, 4'h1, 1);
      repeat (200) @(negedge clk);
      // live updates
      bus(0, 32'hF1, 4'h1, 1);
      wait_pos(2, BLK + 8);
      bus(1, 5, 4'hF, 1);
      wait_pos(2, BLK + 1);
      bus(4, 32'hFF, 4'h1, 1);
      repeat (20) @(negedge clk);
      // abort and restart
      wait_pos(7, BLK + 2);
      bus(0, 32'hF0, 4'h1, 1);
      repeat (10) @(negedge clk);
      bus(0, 32'hF1, 4'h1, 1);
      repeat (100) @(negedge clk);
      // reset mid-scan
      wait_pos(4, BLK + 2);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      bus(0, 0, 4'hF, 0);
      // randomized traffic
      bus(0, 32'hF1, 4'h1, 1);
      bus(1, 2, 4'hF, 1);
      for (int r = 0; r < 40; r++) begin
         a = int'($urandom_range(0, 15));
         d = $urandom;
         if (a == 1) d = d & 32'h1F;
         if (a == 0) d[0] = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 2) == 0) bus(a, 0, 4'hF, 0);
         else bus(a, d, 4'($urandom), 1);
         repeat ($urandom_range(0, 30)) @(negedge clk);
      end
      repeat (5) @(negedge clk);
      n_cmp++;
      if (rdq.size() != 0) begin
         n_bad++;
         $display("FAIL rd_pending: got %0d unanswered reads, want 0", rdq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
